// File: rtl/add_rr_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : add_rr_arbiter
// Brief    : Round-robin arbiter over four requesters feeding a registered
//            WIDTH-bit adder with a one-entry valid/ready output stage.
//            Optional carry event counter enabled by ADD_ARB_CARRY_CNT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module add_rr_arbiter #(
    parameter int WIDTH   = 4,
    parameter int NUM_REQ = 4
) (
    input  logic                     clk_in,
    input  logic                     rst_in,
    input  logic [NUM_REQ-1:0]       req_in,
    input  logic [NUM_REQ*WIDTH-1:0] a_in,
    input  logic [NUM_REQ*WIDTH-1:0] b_in,
    input  logic                     ready_in,
    output logic [NUM_REQ-1:0]       grant_out,
    output logic                     valid_out,
    output logic [1:0]               id_out,
    output logic [WIDTH-1:0]         sum_out,
    output logic                     carry_out
`ifdef ADD_ARB_CARRY_CNT_EN
    ,
    output logic [7:0]               carry_cnt_out
`endif
);

    typedef enum logic [0:0] {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    localparam logic [7:0] c_cnt_max = 8'hFF;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [1:0]         r_ptr;
    logic [1:0]         r_id;
    logic [WIDTH-1:0]   r_sum;
    logic               r_carry;

    logic               w_cap;
    logic               w_found;
    logic [1:0]         w_winner;
    logic [NUM_REQ-1:0] w_grant;
    logic [WIDTH-1:0]   w_opa;
    logic [WIDTH-1:0]   w_opb;
    logic [WIDTH:0]     w_sum_full;

    assign valid_out = (r_state == FULL);
    assign id_out    = r_id;
    assign sum_out   = r_sum;
    assign carry_out = r_carry;
    assign grant_out = w_grant;

    // A new capture is allowed whenever the output slot is empty or is
    // being drained in this same cycle.
    assign w_cap = (|req_in) && (!valid_out || ready_in) && !rst_in;

    // Rotating-priority search starting at the pointer.
    always_comb begin
        w_found  = 1'b0;
        w_winner = r_ptr;
        for (int k = 0; k < 4; k++) begin
            if (!w_found && req_in[r_ptr + 2'(k)]) begin
                w_found  = 1'b1;
                w_winner = r_ptr + 2'(k);
            end
        end
    end

    always_comb begin
        w_grant = '0;
        if (w_cap) begin
            w_grant[w_winner] = 1'b1;
        end
    end

    assign w_opa      = a_in[int'(w_winner)*WIDTH +: WIDTH];
    assign w_opb      = b_in[int'(w_winner)*WIDTH +: WIDTH];
    assign w_sum_full = {1'b0, w_opa} + {1'b0, w_opb};

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            EMPTY:   if (w_cap) w_state_nxt = FULL;
            FULL:    if (!w_cap && ready_in) w_state_nxt = EMPTY;
            default: w_state_nxt = EMPTY;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_state <= EMPTY;
            r_ptr   <= 2'd0;
            r_id    <= 2'd0;
            r_sum   <= '0;
            r_carry <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            // Result registers only move on a capture so a drained result
            // keeps its last value visible.
            if (w_cap) begin
                {r_carry, r_sum} <= w_sum_full;
                r_id             <= w_winner;
                r_ptr            <= w_winner + 2'd1;
            end
        end
    end

`ifdef ADD_ARB_CARRY_CNT_EN
    logic [7:0] r_carry_cnt;

    assign carry_cnt_out = r_carry_cnt;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_carry_cnt <= 8'd0;
        end else if (w_cap && w_sum_full[WIDTH] && (r_carry_cnt != c_cnt_max)) begin
            r_carry_cnt <= r_carry_cnt + 8'd1;
        end
    end
`else
    // Counter absent in this build; the limit constant is kept for clarity.
    logic w_unused_cnt;
    assign w_unused_cnt = &c_cnt_max;
`endif

endmodule
`default_nettype wire

// File: tb/tb_add_rr_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_add_rr_arbiter
// Brief    : Scoreboard testbench for add_rr_arbiter (ADD_ARB_CARRY_CNT_EN aware).
// Revision : 1.0 - initial release
// ============================================================================
module tb_add_rr_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req;
    logic [15:0] a;
    logic [15:0] b;
    logic        ready;
    logic [3:0]  grant_out;
    logic        valid_out;
    logic [1:0]  id_out;
    logic [3:0]  sum_out;
    logic        carry_out;
`ifdef ADD_ARB_CARRY_CNT_EN
    logic [7:0]  carry_cnt_out;
    int          m_cnt;
`endif

    int          errors = 0;
    int          checks = 0;
    logic [6:0]  sb[$];
    logic [6:0]  exp_r;
    logic [3:0]  av[4];
    logic [3:0]  bv[4];

    always #5 clk = ~clk;

    add_rr_arbiter #(.WIDTH(4), .NUM_REQ(4)) dut (
        .clk_in        (clk),
        .rst_in        (rst),
        .req_in        (req),
        .a_in          (a),
        .b_in          (b),
        .ready_in      (ready),
        .grant_out     (grant_out),
        .valid_out     (valid_out),
        .id_out        (id_out),
        .sum_out       (sum_out),
        .carry_out     (carry_out)
`ifdef ADD_ARB_CARRY_CNT_EN
        ,
        .carry_cnt_out (carry_cnt_out)
`endif
    );

    // Expected {id, carry, sum} for requester id with operands x, y.
    function automatic logic [6:0] res(input logic [1:0] id, input logic [3:0] x, input logic [3:0] y);
        logic [4:0] s;
        s = {1'b0, x} + {1'b0, y};
        return {id, s};
    endfunction

    task automatic set_ops(input int i, input logic [3:0] x, input logic [3:0] y);
        a[i*4 +: 4] = x;
        b[i*4 +: 4] = y;
        av[i] = x;
        bv[i] = y;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req = 4'b0000;
        @(posedge clk); #1;
        rst = 1'b0;
        sb.delete();
    endtask

    task automatic test_reset();
        rst = 1'b1; req = 4'b1111; ready = 1'b1;
        @(negedge clk);
        checks++;
        if (grant_out !== 4'b0000) begin errors++; $display("FAIL reset_grant: got %b want 0000", grant_out); end
        @(posedge clk); #1;
        checks++;
        if ({valid_out, id_out, carry_out, sum_out} !== 8'h00) begin
            errors++; $display("FAIL reset_outputs: got %h want 00", {valid_out, id_out, carry_out, sum_out});
        end
`ifdef ADD_ARB_CARRY_CNT_EN
        checks++;
        if (carry_cnt_out !== 8'd0) begin errors++; $display("FAIL reset_cnt: got %0d want 0", carry_cnt_out); end
`endif
        rst = 1'b0; req = 4'b0000;
    endtask

    task automatic test_basic();
        do_reset();
        set_ops(0, 4'h7, 4'h8); ready = 1'b1; req = 4'b0001;
        @(negedge clk);
        checks++;
        if (grant_out !== 4'b0001) begin errors++; $display("FAIL basic_grant: got %b want 0001", grant_out); end
        sb.push_back(res(2'd0, av[0], bv[0]));
        @(posedge clk); #1; req = 4'b0000;
        exp_r = sb.pop_front();
        checks++;
        if ({valid_out, id_out, carry_out, sum_out} !== {1'b1, exp_r}) begin
            errors++; $display("FAIL basic_result: got %h want %h", {valid_out, id_out, carry_out, sum_out}, {1'b1, exp_r});
        end
        @(posedge clk); #1;
        checks++;
        if ({valid_out, id_out, carry_out, sum_out} !== {1'b0, exp_r}) begin
            errors++; $display("FAIL basic_drain_hold: got %h want %h", {valid_out, id_out, carry_out, sum_out}, {1'b0, exp_r});
        end
    endtask

    task automatic test_carry();
        do_reset();
        set_ops(1, 4'hF, 4'h1); ready = 1'b1; req = 4'b0010;
        @(negedge clk);
        checks++;
        if (grant_out !== 4'b0010) begin errors++; $display("FAIL carry_grant: got %b want 0010", grant_out); end
        sb.push_back(res(2'd1, av[1], bv[1]));
        @(posedge clk); #1; req = 4'b0000;
        exp_r = sb.pop_front();
        checks++;
        if ({valid_out, id_out, carry_out, sum_out} !== {1'b1, exp_r}) begin
            errors++; $display("FAIL carry_result: got %h want %h", {valid_out, id_out, carry_out, sum_out}, {1'b1, exp_r});
        end
`ifdef ADD_ARB_CARRY_CNT_EN
        checks++;
        if (carry_cnt_out !== 8'd1) begin errors++; $display("FAIL carry_cnt: got %0d want 1", carry_cnt_out); end
`endif
    endtask

    task automatic test_round_robin();
        do_reset();
        set_ops(0, 4'h1, 4'h3);
        set_ops(1, 4'h2, 4'h9);
        set_ops(2, 4'h3, 4'h5);
        set_ops(3, 4'h4, 4'hF);
        ready = 1'b1; req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            checks++;
            if (grant_out !== (4'b0001 << (k % 4))) begin
                errors++; $display("FAIL rr_grant[%0d]: got %b want %b", k, grant_out, 4'b0001 << (k % 4));
            end
            sb.push_back(res(2'(k % 4), av[k % 4], bv[k % 4]));
            @(posedge clk); #1;
            exp_r = sb.pop_front();
            checks++;
            if ({valid_out, id_out, carry_out, sum_out} !== {1'b1, exp_r}) begin
                errors++; $display("FAIL rr_result[%0d]: got %h want %h", k, {valid_out, id_out, carry_out, sum_out}, {1'b1, exp_r});
            end
        end
        req = 4'b0000;
    endtask

    task automatic test_backpressure();
        do_reset();
        set_ops(0, 4'h1, 4'h2); ready = 1'b1; req = 4'b0001;
        @(negedge clk);
        checks++;
        if (grant_out !== 4'b0001) begin errors++; $display("FAIL bp_first_grant: got %b want 0001", grant_out); end
        sb.push_back(res(2'd0, av[0], bv[0]));
        @(posedge clk); #1;
        exp_r = sb.pop_front();
        checks++;
        if ({valid_out, id_out, carry_out, sum_out} !== {1'b1, exp_r}) begin
            errors++; $display("FAIL bp_first_result: got %h want %h", {valid_out, id_out, carry_out, sum_out}, {1'b1, exp_r});
        end
        ready = 1'b0; req = 4'b0100;
        set_ops(2, 4'h5, 4'h6);
        set_ops(0, 4'hF, 4'hF);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++;
            if (grant_out !== 4'b0000) begin errors++; $display("FAIL bp_stall_grant[%0d]: got %b want 0000", k, grant_out); end
            @(posedge clk); #1;
            checks++;
            if ({valid_out, id_out, carry_out, sum_out} !== {1'b1, exp_r}) begin
                errors++; $display("FAIL bp_stall_hold[%0d]: got %h want %h", k, {valid_out, id_out, carry_out, sum_out}, {1'b1, exp_r});
            end
        end
        set_ops(2, 4'h9, 4'h9);
        ready = 1'b1;
        @(negedge clk);
        checks++;
        if (grant_out !== 4'b0100) begin errors++; $display("FAIL bp_release_grant: got %b want 0100", grant_out); end
        sb.push_back(res(2'd2, av[2], bv[2]));
        @(posedge clk); #1; req = 4'b0000;
        exp_r = sb.pop_front();
        checks++;
        if ({valid_out, id_out, carry_out, sum_out} !== {1'b1, exp_r}) begin
            errors++; $display("FAIL bp_release_result: got %h want %h", {valid_out, id_out, carry_out, sum_out}, {1'b1, exp_r});
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        set_ops(0, 4'h2, 4'h2);
        set_ops(1, 4'h3, 4'h4);
        ready = 1'b1; req = 4'b0010;
        @(negedge clk);
        checks++;
        if (grant_out !== 4'b0010) begin errors++; $display("FAIL rmid_grant: got %b want 0010", grant_out); end
        sb.push_back(res(2'd1, av[1], bv[1]));
        @(posedge clk); #1;
        exp_r = sb.pop_front();
        checks++;
        if ({valid_out, id_out, carry_out, sum_out} !== {1'b1, exp_r}) begin
            errors++; $display("FAIL rmid_result: got %h want %h", {valid_out, id_out, carry_out, sum_out}, {1'b1, exp_r});
        end
        ready = 1'b0; rst = 1'b1; req = 4'b1111;
        @(negedge clk);
        checks++;
        if (grant_out !== 4'b0000) begin errors++; $display("FAIL rmid_rst_grant: got %b want 0000", grant_out); end
        @(posedge clk); #1;
        checks++;
        if ({valid_out, id_out, carry_out, sum_out} !== 8'h00) begin
            errors++; $display("FAIL rmid_discard: got %h want 00", {valid_out, id_out, carry_out, sum_out});
        end
        rst = 1'b0; ready = 1'b1;
        @(negedge clk);
        checks++;
        if (grant_out !== 4'b0001) begin errors++; $display("FAIL rmid_post_grant: got %b want 0001", grant_out); end
        sb.push_back(res(2'd0, av[0], bv[0]));
        @(posedge clk); #1; req = 4'b0000;
        exp_r = sb.pop_front();
        checks++;
        if ({valid_out, id_out, carry_out, sum_out} !== {1'b1, exp_r}) begin
            errors++; $display("FAIL rmid_post_result: got %h want %h", {valid_out, id_out, carry_out, sum_out}, {1'b1, exp_r});
        end
    endtask

`ifdef ADD_ARB_CARRY_CNT_EN
    task automatic test_saturate();
        do_reset();
        m_cnt = 0;
        set_ops(0, 4'hF, 4'hF); ready = 1'b1; req = 4'b0001;
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            sb.push_back(res(2'd0, av[0], bv[0]));
            @(posedge clk); #1;
            exp_r = sb.pop_front();
            m_cnt = (m_cnt == 255) ? 255 : m_cnt + 1;
            checks++;
            if ({valid_out, id_out, carry_out, sum_out} !== {1'b1, exp_r}) begin
                errors++; $display("FAIL sat_result[%0d]: got %h want %h", n, {valid_out, id_out, carry_out, sum_out}, {1'b1, exp_r});
            end
            checks++;
            if (carry_cnt_out !== 8'(m_cnt)) begin
                errors++; $display("FAIL sat_cnt[%0d]: got %0d want %0d", n, carry_cnt_out, m_cnt);
            end
        end
        req = 4'b0000;
    endtask
`endif

    initial begin
        rst = 1'b1; req = 4'b0000; ready = 1'b1; a = '0; b = '0;
        for (int i = 0; i < 4; i++) begin
            av[i] = 4'h0;
            bv[i] = 4'h0;
        end
        test_reset();
        test_basic();
        test_carry();
        test_round_robin();
        test_backpressure();
        test_reset_mid();
`ifdef ADD_ARB_CARRY_CNT_EN
        test_saturate();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/add_rr_arbiter.md
ADD_RR_ARBITER -- requirements
Module: add_rr_arbiter

Interface
REQ-001 SHALL have parameter: WIDTH, 4, operand width per requester.
REQ-002 SHALL have parameter: NUM_REQ, 4, requester count; fixed at 4, other values unsupported.
REQ-003 SHALL use one clock; reset is synchronous and active-high.
REQ-004 SHALL have port: clk_in  input  1  sole clock, rising edge.
REQ-005 SHALL have port: rst_in  input  1  synchronous active-high reset.
REQ-006 SHALL have port: req_in  input  4  request per requester i, held until granted.
REQ-007 SHALL have port: a_in  input  4*WIDTH  operand A; requester i at bits [i*WIDTH +: WIDTH].
REQ-008 SHALL have port: b_in  input  4*WIDTH  operand B; same packing as a_in.
REQ-009 SHALL have port: ready_in  input  1  consumer accepts the result when high with valid_out.
REQ-010 SHALL have port: grant_out  output  4  one-hot grant, combinational, high in the operand-capture cycle.
REQ-011 SHALL have port: valid_out  output  1  registered result valid.
REQ-012 SHALL have port: id_out  output  2  index of the requester owning the result.
REQ-013 SHALL have port: sum_out  output  WIDTH  registered sum.
REQ-014 SHALL have port: carry_out  output  1  registered carry (bit WIDTH of the sum).
REQ-015 SHALL have port: carry_cnt_out  output  8  carry event count; present only under ADD_ARB_CARRY_CNT_EN.

Function
REQ-016 SHALL define cap = (req_in != 0) && (!valid_out || ready_in) && !rst_in.
REQ-017 SHALL select the winner as the first i with req_in[i]=1, searching ptr, ptr+1, ... mod 4.
REQ-018 SHALL drive grant_out = onehot(winner) when cap=1, else 4'b0000; never more than one bit set.
REQ-019 SHALL, on an edge with cap=1, load {carry_out,sum_out} <= a[winner] + b[winner] at WIDTH+1 bits, id_out <= winner, valid_out <= 1, ptr <= (winner+1) mod 4.
REQ-020 SHALL have a latency of one cycle: the result is visible the cycle after grant.
REQ-021 SHALL sustain one result per cycle while ready_in=1 and requests are pending; back-to-back captures need no idle cycle.
REQ-022 SHALL, on an edge with valid_out=1, ready_in=1 and cap=0, clear valid_out and hold sum_out, carry_out and id_out at their last values.
REQ-023 SHALL, while valid_out=1 and ready_in=0, hold all registered outputs stable, drive grant_out=0 and leave ptr unchanged.
REQ-024 SHALL implement two states: EMPTY (valid_out=0) and FULL (valid_out=1).
REQ-025 SHALL transition EMPTY->FULL on cap, FULL->FULL on cap or !ready_in, and FULL->EMPTY on ready_in && !cap.
REQ-026 SHALL wrap ptr from 3 to 0; a lone persistent requester is granted every cycle.
REQ-027 SHALL use a requester's operands only in its grant cycle; operand changes at other times have no effect.

Reset
REQ-028 SHALL, on an edge with rst_in=1, set valid_out=0, sum_out=0, carry_out=0, id_out=0, ptr=0 and carry_cnt_out=0.
REQ-029 SHALL force grant_out=0 while rst_in=1.
REQ-030 SHALL discard a pending unaccepted result when reset is asserted mid-operation.

Configuration
REQ-031 SHALL, with ADD_ARB_CARRY_CNT_EN defined, increment carry_cnt_out on each capture whose carry is 1, saturating at 255.
REQ-032 SHALL, with ADD_ARB_CARRY_CNT_EN undefined, omit the carry_cnt_out port and the counter logic; all other behaviour is identical.

Verification
REQ-033 SHALL cover: after reset, req_in=0001, a0=7, b0=8, ready_in=1 -> grant_out=0001 that cycle; next cycle valid_out=1, id_out=0, sum_out=F, carry_out=0.
REQ-034 SHALL cover: req_in=0010, a1=F, b1=1 -> sum_out=0, carry_out=1, id_out=1; with the macro, carry_cnt_out=1.
REQ-035 SHALL cover: req_in held at 1111, ready_in=1 -> grants 0001, 0010, 0100, 1000, 0001 on consecutive cycles; id_out=0,1,2,3,0 one cycle later.
REQ-036 SHALL cover: valid_out=1, ready_in=0, req_in=0100 -> grant_out=0000 and outputs stable for 3 cycles; ready_in=1 -> grant_out=0100 that cycle, new result next cycle.
REQ-037 SHALL cover: valid_out=1, then rst_in=1 for one cycle with req_in=1111 -> grant_out=0000 during reset, valid_out=0 next cycle, first grant after reset is 0001.
REQ-038 SHALL cover, with the macro: 300 captures of a=F, b=F -> carry_cnt_out saturates at 255.
